// File: rtl/local_sp_uram_1r1w_pipe_pkg.sv
// Shared types and helpers for the 1R1W pipelined URAM local scratchpad.
// Optional write-first bypass is enabled with LOCAL_SP_URAM_RAW_BYPASS_EN.
package local_sp_uram_pkg;

   localparam int MAX_READ_LATENCY = 4;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      DONE
   } clr_state_t;

   function automatic logic [7:0] be_merge(input logic [7:0] old_byte,
                                           input logic [7:0] new_byte,
                                           input logic       be);
      return be ? new_byte : old_byte;
   endfunction

endpackage

// File: rtl/local_sp_uram_1r1w_pipe_if.sv
// Read/write/clear bus of the 1R1W pipelined URAM local scratchpad.
// master = kernel logic issuing requests, slave = the scratchpad.
interface local_sp_uram_1r1w_pipe_if #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 11
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [BE_WIDTH-1:0]   wr_be;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  clr_start;
   logic                  clr_busy;

   modport master (
      output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr, clr_start,
      input  rd_data, rd_valid, clr_busy
   );

   modport slave (
      input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr, clr_start,
      output rd_data, rd_valid, clr_busy
   );

endinterface

// File: rtl/local_sp_uram_1r1w_pipe_rd_stage.sv
// One register of the read-data pipeline; with LOCAL_SP_URAM_RAW_BYPASS_EN
// it also patches the passing word with a matching same-cycle write.
module local_sp_uram_rd_stage
   import local_sp_uram_pkg::*;
#(
`ifdef LOCAL_SP_URAM_RAW_BYPASS_EN
   parameter int ADDR_WIDTH = 11,
`endif
   parameter int DATA_WIDTH = 256
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic [DATA_WIDTH-1:0]   in_data,
`ifdef LOCAL_SP_URAM_RAW_BYPASS_EN
   input  logic [ADDR_WIDTH-1:0]   in_addr,
   input  logic                    wr_en,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [DATA_WIDTH/8-1:0] wr_be,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   output logic [ADDR_WIDTH-1:0]   addr,
`endif
   output logic                    valid,
   output logic [DATA_WIDTH-1:0]   data
);

   logic [DATA_WIDTH-1:0] next_data;

`ifdef LOCAL_SP_URAM_RAW_BYPASS_EN
   always_comb begin
      next_data = in_data;
      if (wr_en && (wr_addr == in_addr)) begin
         for (int b = 0; b < DATA_WIDTH/8; b++) begin
            next_data[b*8 +: 8] = be_merge(in_data[b*8 +: 8], wr_data[b*8 +: 8], wr_be[b]);
         end
      end
   end
`else
   assign next_data = in_data;
`endif

   // Data only moves with a valid word, so the last stage holds rd_data between reads.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
`ifdef LOCAL_SP_URAM_RAW_BYPASS_EN
         addr  <= '0;
`endif
      end else begin
         valid <= in_valid;
         if (in_valid) begin
            data <= next_data;
`ifdef LOCAL_SP_URAM_RAW_BYPASS_EN
            addr <= in_addr;
`endif
         end
      end
   end

endmodule

// File: rtl/local_sp_uram_1r1w_pipe.sv
// 1R1W byte-enable URAM scratchpad with a configurable read pipeline and a clear engine.
// Define LOCAL_SP_URAM_RAW_BYPASS_EN for write-first coherence of in-flight reads.
module local_sp_uram_1r1w_pipe
   import local_sp_uram_pkg::*;
#(
   parameter int DATA_WIDTH     = 256,
   parameter int DEPTH          = 2048,
   parameter int ADDR_WIDTH     = 11,
   parameter int READ_LATENCY   = 2,
   parameter int CLEAR_ON_RESET = 0
) (
   input logic                     clk,
   input logic                     reset,
   local_sp_uram_1r1w_pipe_if.slave bus
);

   localparam int BE_WIDTH  = DATA_WIDTH / 8;
   localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LAT       = (READ_LATENCY < 1) ? 1 :
                              (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;
   localparam logic [ADDR_WIDTH:0]  DEPTH_LIMIT = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [IDX_WIDTH-1:0] LAST_IDX    = IDX_WIDTH'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   clr_state_t            clr_state;
   logic [IDX_WIDTH-1:0]  clr_cnt;
   logic                  clr_busy_q;
   logic                  auto_pending;

   logic                  wr_in_range;
   logic                  rd_in_range;
   logic                  rd_accept;
   logic                  mem_wr;
   logic [IDX_WIDTH-1:0]  mem_idx;
   logic [BE_WIDTH-1:0]   mem_be;
   logic [DATA_WIDTH-1:0] mem_data;
   logic [DATA_WIDTH-1:0] rd_word;

   logic [LAT:0]                 stg_valid;
   logic [LAT:0][DATA_WIDTH-1:0] stg_data;

   assign wr_in_range = {1'b0, bus.wr_addr} < DEPTH_LIMIT;
   assign rd_in_range = {1'b0, bus.rd_addr} < DEPTH_LIMIT;
   assign rd_accept   = bus.rd_en && !clr_busy_q;

   // Clear engine owns the single write port while busy; external writes are dropped then.
   always_comb begin
      mem_wr   = clr_busy_q || (bus.wr_en && wr_in_range);
      mem_idx  = clr_busy_q ? clr_cnt : bus.wr_addr[IDX_WIDTH-1:0];
      mem_be   = clr_busy_q ? '1 : bus.wr_be;
      mem_data = clr_busy_q ? '0 : bus.wr_data;
   end

   always_ff @(posedge clk) begin
      if (mem_wr) begin
         for (int b = 0; b < BE_WIDTH; b++) begin
            if (mem_be[b]) begin
               mem[mem_idx][b*8 +: 8] <= mem_data[b*8 +: 8];
            end
         end
      end
   end

   // Combinational array read captured by stage 1 gives read-first on collisions.
   assign rd_word = rd_in_range ? mem[bus.rd_addr[IDX_WIDTH-1:0]] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         clr_state    <= IDLE;
         clr_cnt      <= '0;
         clr_busy_q   <= 1'b0;
         auto_pending <= (CLEAR_ON_RESET != 0);
      end else begin
         case (clr_state)
            IDLE: begin
               if (bus.clr_start || auto_pending) begin
                  clr_state    <= CLEAR;
                  clr_cnt      <= '0;
                  clr_busy_q   <= 1'b1;
                  auto_pending <= 1'b0;
               end
            end
            CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == LAST_IDX) begin
                  clr_state  <= DONE;
                  clr_busy_q <= 1'b0;
               end
            end
            DONE: begin
               clr_state <= IDLE;
            end
            default: begin
               clr_state  <= IDLE;
               clr_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign stg_valid[0] = rd_accept;
   assign stg_data[0]  = rd_word;

`ifdef LOCAL_SP_URAM_RAW_BYPASS_EN
   logic [LAT:0][ADDR_WIDTH-1:0] stg_addr;
   logic [ADDR_WIDTH-1:0]        byp_addr;

   assign stg_addr[0] = bus.rd_addr;
   assign byp_addr    = clr_busy_q ? ADDR_WIDTH'(clr_cnt) : bus.wr_addr;
`endif

   for (genvar s = 0; s < LAT; s++) begin : g_stage
      local_sp_uram_rd_stage #(
`ifdef LOCAL_SP_URAM_RAW_BYPASS_EN
         .ADDR_WIDTH (ADDR_WIDTH),
`endif
         .DATA_WIDTH (DATA_WIDTH)
      ) u_stage (
         .clk      (clk),
         .reset    (reset),
         .in_valid (stg_valid[s]),
         .in_data  (stg_data[s]),
`ifdef LOCAL_SP_URAM_RAW_BYPASS_EN
         .in_addr  (stg_addr[s]),
         .wr_en    (mem_wr),
         .wr_addr  (byp_addr),
         .wr_be    (mem_be),
         .wr_data  (mem_data),
         .addr     (stg_addr[s+1]),
`endif
         .valid    (stg_valid[s+1]),
         .data     (stg_data[s+1])
      );
   end

   assign bus.rd_valid = stg_valid[LAT];
   assign bus.rd_data  = stg_data[LAT];
   assign bus.clr_busy = clr_busy_q;

endmodule

// File: tb/tb_local_sp_uram_1r1w_pipe.sv
// Self-checking bench for local_sp_uram_1r1w_pipe (DEPTH=100, READ_LATENCY=2);
// expectations come from an array/queue model of the scratchpad's behaviour.
module tb_local_sp_uram_1r1w_pipe;

   localparam int DW    = 64;
   localparam int DEPTH = 100;
   localparam int AW    = 8;
   localparam int LAT   = 2;
   localparam int BEW   = DW / 8;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   local_sp_uram_1r1w_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   local_sp_uram_1r1w_pipe #(
      .DATA_WIDTH     (DW),
      .DEPTH          (DEPTH),
      .ADDR_WIDTH     (AW),
      .READ_LATENCY   (LAT),
      .CLEAR_ON_RESET (0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: word array, queue of outstanding reads with due cycle, clear countdown.
   typedef struct {
      int          addr;
      int          due;
      logic [DW-1:0] data;
   } rd_t;

   rd_t           pend[$];
   logic [DW-1:0] model_mem [DEPTH];
   int            cyc    = 0;
   int            m_rem  = 0;
   bit            m_done = 1'b0;
   logic [DW-1:0] exp_hold = '0;
   logic [DW-1:0] exp_data, obs_data;
   logic          exp_valid, exp_busy, obs_valid, obs_busy;

   function automatic void model_write(input int a, input logic [BEW-1:0] be, input logic [DW-1:0] d);
      for (int b = 0; b < BEW; b++) begin
         if (be[b]) model_mem[a][b*8 +: 8] = d[b*8 +: 8];
      end
`ifdef LOCAL_SP_URAM_RAW_BYPASS_EN
      for (int i = 0; i < pend.size(); i++) begin
         if (pend[i].addr == a && pend[i].due > cyc) begin
            rd_t e = pend[i];
            for (int b = 0; b < BEW; b++) begin
               if (be[b]) e.data[b*8 +: 8] = d[b*8 +: 8];
            end
            pend[i] = e;
         end
      end
`endif
   endfunction

   // Drives one cycle, advances the model, samples DUT outputs at the following negedge.
   task automatic applyStimulus(input logic rst, input logic we, input int wa,
                                input logic [BEW-1:0] be, input logic [DW-1:0] wd,
                                input logic re, input int ra, input logic cs);
      bit  busy;
      rd_t e;
      reset         = rst;
      bus.wr_en     = we;
      bus.wr_addr   = AW'(wa);
      bus.wr_be     = be;
      bus.wr_data   = wd;
      bus.rd_en     = re;
      bus.rd_addr   = AW'(ra);
      bus.clr_start = cs;
      @(posedge clk);
      busy = (m_rem > 0);
      if (rst) begin
         pend.delete();
         m_rem    = 0;
         m_done   = 1'b0;
         exp_hold = '0;
      end else begin
         if (re && !busy) begin
            e.addr = ra;
            e.due  = cyc + LAT;
            e.data = (ra < DEPTH) ? model_mem[ra] : '0;
            pend.push_back(e);
         end
         if (busy) model_write(DEPTH - m_rem, '1, '0);
         else if (we && wa < DEPTH) model_write(wa, be, wd);
         if (busy) begin
            m_rem--;
            m_done = (m_rem == 0);
         end else if (m_done) begin
            m_done = 1'b0;
         end else if (cs) begin
            m_rem = DEPTH;
         end
      end
      cyc++;
      @(negedge clk);
      obs_valid = bus.rd_valid;
      obs_data  = bus.rd_data;
      obs_busy  = bus.clr_busy;
      exp_valid = (pend.size() > 0) && (pend[0].due == cyc);
      if (exp_valid) begin
         exp_hold = pend[0].data;
         void'(pend.pop_front());
      end
      exp_data = exp_hold;
      exp_busy = (m_rem > 0);
   endtask

   task automatic writeWord(input int a, input logic [BEW-1:0] be, input logic [DW-1:0] d);
      applyStimulus(1'b0, 1'b1, a, be, d, 1'b0, 0, 1'b0);
   endtask

   // Issues one read at ra, optional writes to ra in the rd_en cycle and the one after.
   task automatic readWithWrites(input int ra, input logic w0, input logic [DW-1:0] d0,
                                 input logic w1, input logic [DW-1:0] d1,
                                 output int lat, output int pulses, output logic [DW-1:0] d);
      lat    = -1;
      pulses = 0;
      d      = '0;
      for (int i = 1; i <= 6; i++) begin
         applyStimulus(1'b0, (i == 1) ? w0 : ((i == 2) ? w1 : 1'b0), ra, '1,
                       (i == 1) ? d0 : d1, i == 1, ra, 1'b0);
         if (obs_valid) begin
            pulses++;
            if (lat < 0) begin
               lat = i;
               d   = obs_data;
            end
         end
      end
   endtask

   task automatic test_reset();
      applyStimulus(1'b1, 1'b0, 0, '0, '0, 1'b0, 0, 1'b0);
      applyStimulus(1'b1, 1'b0, 0, '0, '0, 1'b0, 0, 1'b0);
      n_tests++; if (obs_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", obs_valid); end
      n_tests++; if (obs_data !== '0) begin n_fail++; $display("[TB] FAIL reset_data: got %h expected 0", obs_data); end
      n_tests++; if (obs_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", obs_busy); end
   endtask

   task automatic test_clear();
      int            busy_cycles;
      logic [DW-1:0] got[$];
      applyStimulus(1'b0, 1'b0, 0, '0, '0, 1'b0, 0, 1'b1);
      busy_cycles = obs_busy ? 1 : 0;
      for (int i = 0; i < DEPTH + 10; i++) begin
         applyStimulus(1'b0, i == 50, 10, '1, 64'hDEAD_BEEF_0123_4567, i == 30, 10, i == 20);
         if (obs_busy) busy_cycles++;
         n_tests++; if (obs_busy !== exp_busy) begin n_fail++; $display("[TB] FAIL clear_busy[%0d]: got %b expected %b", i, obs_busy, exp_busy); end
         n_tests++; if (obs_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL clear_valid[%0d]: got %b expected %b", i, obs_valid, exp_valid); end
      end
      n_tests++; if (busy_cycles != DEPTH) begin n_fail++; $display("[TB] FAIL clear_duration: got %0d expected %0d", busy_cycles, DEPTH); end
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'b0, 0, '0, '0, i < 3, (i == 0) ? 0 : ((i == 1) ? 99 : 10), 1'b0);
         if (obs_valid) got.push_back(obs_data);
      end
      n_tests++; if (got.size() != 3) begin n_fail++; $display("[TB] FAIL clear_readback_count: got %0d expected 3", got.size()); end
      foreach (got[k]) begin
         n_tests++; if (got[k] !== '0) begin n_fail++; $display("[TB] FAIL clear_readback[%0d]: got %h expected 0", k, got[k]); end
      end
   endtask

   task automatic test_write_read();
      int            lat, pulses;
      logic [DW-1:0] d;
      writeWord(5, '1, {BEW{8'hA5}});
      readWithWrites(5, 1'b0, '0, 1'b0, '0, lat, pulses, d);
      n_tests++; if (lat != LAT) begin n_fail++; $display("[TB] FAIL wr_rd_latency: got %0d expected %0d", lat, LAT); end
      n_tests++; if (pulses != 1) begin n_fail++; $display("[TB] FAIL wr_rd_pulses: got %0d expected 1", pulses); end
      n_tests++; if (d !== {BEW{8'hA5}}) begin n_fail++; $display("[TB] FAIL wr_rd_data: got %h expected %h", d, {BEW{8'hA5}}); end
   endtask

   task automatic test_byte_enable();
      int            lat, pulses;
      logic [DW-1:0] d;
      writeWord(7, '1, '0);
      writeWord(7, BEW'(1), '1);
      readWithWrites(7, 1'b0, '0, 1'b0, '0, lat, pulses, d);
      n_tests++; if (d !== 64'h0000_0000_0000_00FF) begin n_fail++; $display("[TB] FAIL byte_enable: got %h expected 00000000000000ff", d); end
      writeWord(7, '0, '1);
      readWithWrites(7, 1'b0, '0, 1'b0, '0, lat, pulses, d);
      n_tests++; if (d !== 64'h0000_0000_0000_00FF) begin n_fail++; $display("[TB] FAIL be_zero_noop: got %h expected 00000000000000ff", d); end
   endtask

   task automatic test_collision();
      int            lat, pulses;
      logic [DW-1:0] d, x_val, y_val, z_val, want;
      x_val = 64'h1111_2222_3333_4444;
      y_val = 64'h5555_6666_7777_8888;
      z_val = 64'h9999_AAAA_BBBB_CCCC;
      writeWord(3, '1, y_val);
      readWithWrites(3, 1'b1, x_val, 1'b0, '0, lat, pulses, d);
`ifdef LOCAL_SP_URAM_RAW_BYPASS_EN
      want = x_val;
`else
      want = y_val;
`endif
      n_tests++; if (d !== want) begin n_fail++; $display("[TB] FAIL collision_same_cycle: got %h expected %h", d, want); end
      readWithWrites(3, 1'b0, '0, 1'b1, z_val, lat, pulses, d);
`ifdef LOCAL_SP_URAM_RAW_BYPASS_EN
      want = z_val;
`else
      want = x_val;
`endif
      n_tests++; if (d !== want) begin n_fail++; $display("[TB] FAIL collision_next_cycle: got %h expected %h", d, want); end
   endtask

   task automatic test_out_of_range();
      int            lat, pulses;
      logic [DW-1:0] d;
      writeWord(72, '1, 64'h0F0F_1234_5678_0F0F);
      writeWord(200, '1, 64'hFFFF_0000_FFFF_0000);
      writeWord(120, '1, 64'hCAFE_CAFE_CAFE_CAFE);
      readWithWrites(120, 1'b0, '0, 1'b0, '0, lat, pulses, d);
      n_tests++; if (lat != LAT) begin n_fail++; $display("[TB] FAIL oor_latency: got %0d expected %0d", lat, LAT); end
      n_tests++; if (d !== '0) begin n_fail++; $display("[TB] FAIL oor_data: got %h expected 0", d); end
      readWithWrites(72, 1'b0, '0, 1'b0, '0, lat, pulses, d);
      n_tests++; if (d !== 64'h0F0F_1234_5678_0F0F) begin n_fail++; $display("[TB] FAIL oor_alias: got %h expected 0f0f123456780f0f", d); end
      readWithWrites(99, 1'b0, '0, 1'b0, '0, lat, pulses, d);
      n_tests++; if (d !== '0) begin n_fail++; $display("[TB] FAIL oor_last_addr: got %h expected 0", d); end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] vals[5];
      logic [DW-1:0] got[$];
      for (int i = 0; i < 5; i++) begin
         vals[i] = {$urandom, $urandom};
         writeWord(40 + i, '1, vals[i]);
      end
      for (int i = 0; i < 5 + LAT + 1; i++) begin
         applyStimulus(1'b0, 1'b0, 0, '0, '0, i < 5, 40 + i, 1'b0);
         if (obs_valid) got.push_back(obs_data);
         n_tests++; if (obs_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL b2b_valid[%0d]: got %b expected %b", i, obs_valid, exp_valid); end
      end
      n_tests++; if (got.size() != 5) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d expected 5", got.size()); end
      for (int i = 0; i < 5 && i < got.size(); i++) begin
         n_tests++; if (got[i] !== vals[i]) begin n_fail++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", i, got[i], vals[i]); end
      end
   endtask

   task automatic test_random();
      int wa, ra;
      for (int i = 0; i < 400; i++) begin
         wa = ($urandom_range(0, 9) < 8) ? $urandom_range(0, DEPTH - 1) : $urandom_range(DEPTH, 255);
         ra = ($urandom_range(0, 9) < 8) ? $urandom_range(0, DEPTH - 1) : $urandom_range(DEPTH, 255);
         if ($urandom_range(0, 3) == 0) ra = wa;
         applyStimulus(1'b0, $urandom_range(0, 1) == 1, wa, BEW'($urandom), {$urandom, $urandom},
                       $urandom_range(0, 2) != 0, ra, $urandom_range(0, 299) == 0);
         n_tests++; if (obs_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL rand_valid[%0d]: got %b expected %b", i, obs_valid, exp_valid); end
         n_tests++; if (obs_data !== exp_data) begin n_fail++; $display("[TB] FAIL rand_data[%0d]: got %h expected %h", i, obs_data, exp_data); end
         n_tests++; if (obs_busy !== exp_busy) begin n_fail++; $display("[TB] FAIL rand_busy[%0d]: got %b expected %b", i, obs_busy, exp_busy); end
      end
      for (int i = 0; i < DEPTH + 5; i++) applyStimulus(1'b0, 1'b0, 0, '0, '0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_reset_mid();
      // Reset on the tenth clear cycle.
      applyStimulus(1'b0, 1'b0, 0, '0, '0, 1'b0, 0, 1'b1);
      for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 0, '0, '0, 1'b0, 0, 1'b0);
      n_tests++; if (obs_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_clear_busy_before: got %b expected 1", obs_busy); end
      applyStimulus(1'b1, 1'b0, 0, '0, '0, 1'b0, 0, 1'b0);
      n_tests++; if (obs_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_clear_busy_after: got %b expected 0", obs_busy); end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 0, '0, '0, 1'b0, 0, 1'b0);
         n_tests++; if (obs_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_clear_idle_busy[%0d]: got %b expected 0", i, obs_busy); end
      end
      // Reset with reads still in the pipeline.
      applyStimulus(1'b0, 1'b0, 0, '0, '0, 1'b1, 5, 1'b0);
      applyStimulus(1'b0, 1'b0, 0, '0, '0, 1'b1, 6, 1'b0);
      applyStimulus(1'b1, 1'b0, 0, '0, '0, 1'b0, 0, 1'b0);
      n_tests++; if (obs_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_read_valid: got %b expected 0", obs_valid); end
      n_tests++; if (obs_data !== '0) begin n_fail++; $display("[TB] FAIL mid_read_data: got %h expected 0", obs_data); end
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 0, '0, '0, 1'b0, 0, 1'b0);
         n_tests++; if (obs_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_read_after[%0d]: got %b expected 0", i, obs_valid); end
      end
   endtask

   initial begin
      reset         = 1'b1;
      bus.wr_en     = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_be     = '0;
      bus.wr_data   = '0;
      bus.rd_en     = 1'b0;
      bus.rd_addr   = '0;
      bus.clr_start = 1'b0;
      test_reset();
      test_clear();
      test_write_read();
      test_byte_enable();
      test_collision();
      test_out_of_range();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/local_sp_uram_1r1w_pipe.md
Name: local_sp_uram_1r1w_pipe

Overview:
- Parametrised successor to the kernel's single-port URAM local scratchpad.
- Separate read and write ports; byte-enable writes; configurable read-latency pipeline with a valid flag; hardware clear engine.
- Instantiated per local scratchpad (e.g. KNN partial-distance buffers) behind HLS-generated kernel logic.
- Storage infers URAM; only the output pipeline and control logic are reset.

Parameters:
- DATA_WIDTH, 256, word width in bits; must be a multiple of 8.
- DEPTH, 2048, number of words; need not be a power of two.
- ADDR_WIDTH, 11, address width; must be ≥ clog2(DEPTH).
- READ_LATENCY, 2, cycles from rd_en to rd_valid; legal range 1..4.
- CLEAR_ON_RESET, 0, 1 = the clear engine starts automatically when reset deasserts.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_be  in  DATA_WIDTH/8  byte enables.
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data, held until the next rd_valid.
- rd_valid  out  1  one-cycle pulse, READ_LATENCY cycles after an accepted rd_en.
- clr_start  in  1  starts the clear engine.
- clr_busy  out  1  high while the clear engine runs.

Behaviour:
- Reset values: rd_data=0, rd_valid=0, clr_busy=0, all pipeline valid bits=0. Array contents are not reset.
- If CLEAR_ON_RESET=1, the clear engine enters CLEAR on the first cycle after reset deasserts.
- Write: on wr_en, bytes with wr_be[i]=1 are written at wr_addr at the clock edge. Other bytes keep their old value. wr_be=0 is a no-op.
- Read pipeline:
  - An accepted rd_en registers the array word in stage 1.
  - Stages 2..READ_LATENCY are plain registers.
  - rd_valid and rd_data update together on exit from the last stage.
  - One read is accepted per cycle; reads are fully pipelined with no stalls.
- Out of range (address ≥ DEPTH):
  - writes are dropped;
  - reads are accepted and return all zeros with rd_valid asserted at normal latency.
- Same-cycle read and write to the same address: read-first. The read returns the old word. Bypass applies only with the optional feature.
- Clear engine FSM, states IDLE, CLEAR, DONE:
  - IDLE→CLEAR on clr_start (or auto-start). The counter loads 0 and clr_busy=1.
  - CLEAR: writes 0 to address cnt each cycle, cnt++. At cnt=DEPTH-1, goes to DONE. Duration is exactly DEPTH cycles.
  - DONE: clr_busy=0, then IDLE in the next cycle. DONE lasts 1 cycle.
  - clr_start while busy is ignored.
- While clr_busy=1:
  - external wr_en is dropped;
  - rd_en is not accepted and produces no rd_valid;
  - reads already in flight complete normally.
- Reset mid-clear: FSM returns to IDLE and clr_busy=0 next cycle. Contents are partially cleared; that is legal.
- Reset mid-read: in-flight reads are discarded and no rd_valid is produced.

Optional Feature:
- Macro: LOCAL_SP_URAM_RAW_BYPASS_EN.
- Defined: write-first coherence. Each in-flight read stage compares its address with the current write. On a match, enabled bytes of that stage's data are replaced with wr_data, including a same-cycle collision at stage 1. rd_data therefore always reflects every write issued up to and including the rd_en cycle and up to the cycle before the word leaves the pipeline. Clear-engine writes are bypassed the same way.
- Undefined: no comparators. Read-first at the array; data in flight is never patched.

Decomposition:
- Package local_sp_uram_pkg holds:
  - the clear FSM state enum (IDLE/CLEAR/DONE);
  - function be_merge(old, new, be);
  - constant MAX_READ_LATENCY=4.
- One sub-module, local_sp_uram_rd_stage, implements a single pipeline register: valid, addr, data, plus the optional bypass merge. It is generated READ_LATENCY times.

Test Plan:
- Write 0xA5…A5 to addr 5 with all wr_be set, then read addr 5 (READ_LATENCY=2) → rd_valid exactly 2 cycles after rd_en, rd_data=0xA5…A5.
- Write 0x00…00 to addr 7, then write 0xFF…FF with wr_be=0x…0001, then read addr 7 → only byte 0 = 0xFF, all other bytes 0x00.
- Same cycle: wr addr 3 = X while rd addr 3, old value Y.
  - Macro undefined → Y.
  - Macro defined → X.
  - Macro defined, wr addr 3 = Z one cycle after the rd → Z.
- DEPTH=100: pulse clr_start → clr_busy high 100 cycles; a write at cycle 50 is dropped; after DONE, reads of addr 0 and addr 99 return 0.
- DEPTH=100: read addr 120 → rd_valid at normal latency with data 0; write to addr 120 has no effect on any legal address.
- Assert reset during the clear at cycle 10 and with 2 reads in flight → clr_busy=0 and rd_valid=0 next cycle; no rd_valid afterwards.
